// File: rtl/usb_rx_ll.sv
// Full-speed USB receive link layer: 4-phase DPLL bit recovery, SYNC detect,
// NRZI decode, bit unstuffing and EOP/error framing toward the deserializer.
module usb_rx_ll #(
    parameter int unsigned SAMPLE_PHASE = 2,
    parameter int unsigned IDLE_BITS    = 7
) (
    input  logic clk,
    input  logic rst_n,
    input  logic phy_rx_dp,
    input  logic phy_rx_dn,
    input  logic phy_rx_chg,
    input  logic rx_en,
    output logic ll_start,
    output logic ll_valid,
    output logic ll_data,
    output logic ll_eop,
    output logic ll_err,
    output logic ll_active
);
    localparam int unsigned PHASE_W = 2;
    localparam int unsigned CNT_W   = 3;
    localparam int unsigned JCNT_W  = $clog2(IDLE_BITS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_ACTIVE,
        S_EOP,
        S_ERROR
    } state_t;

    state_t              state;
    logic [PHASE_W-1:0]  phase;
    logic                prev_j;
    logic [CNT_W-1:0]    zcnt;
    logic [CNT_W-1:0]    ones;
    logic [CNT_W-1:0]    se0cnt;
    logic [JCNT_W-1:0]   jcnt;
    logic                se0_seen;

    logic sym_j, sym_k, sym_se0, sym_se1;
    logic strobe;
    logic nrzi_bit;

    assign sym_j    = phy_rx_dp & ~phy_rx_dn;
    assign sym_k    = ~phy_rx_dp & phy_rx_dn;
    assign sym_se0  = ~phy_rx_dp & ~phy_rx_dn;
    assign sym_se1  = phy_rx_dp & phy_rx_dn;
    // A line edge re-centres the DPLL and suppresses a coincident sample
    assign strobe   = (phase == PHASE_W'(SAMPLE_PHASE)) && !phy_rx_chg;
    assign nrzi_bit = (sym_j == prev_j);

    // Bit-timing DPLL: edges restart the phase, otherwise free-run mod 4
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= '0;
        end else if (phy_rx_chg) begin
            phase <= PHASE_W'(1);
        end else begin
            phase <= phase + PHASE_W'(1);
        end
    end

    // Link-layer FSM with registered strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            prev_j    <= 1'b1;
            zcnt      <= '0;
            ones      <= '0;
            se0cnt    <= '0;
            jcnt      <= '0;
            se0_seen  <= 1'b0;
            ll_start  <= 1'b0;
            ll_valid  <= 1'b0;
            ll_data   <= 1'b0;
            ll_eop    <= 1'b0;
            ll_err    <= 1'b0;
            ll_active <= 1'b0;
        end else begin
            ll_start  <= 1'b0;
            ll_valid  <= 1'b0;
            ll_eop    <= 1'b0;
            ll_err    <= 1'b0;
            ll_active <= ll_active & ~(ll_eop | ll_err);

            if (!rx_en) begin
                // Controller is transmitting: abort any packet in flight exactly once
                state  <= S_IDLE;
                prev_j <= 1'b1;
                if (ll_active && !ll_eop && !ll_err) begin
                    ll_err <= 1'b1;
                end
            end else if (strobe) begin
                // ERROR exit trackers start fresh from the sample that enters ERROR
                if (state != S_ERROR) begin
                    jcnt     <= '0;
                    se0_seen <= sym_se0;
                end
                if (sym_j || sym_k) begin
                    prev_j <= sym_j;
                end

                case (state)
                    S_IDLE: begin
                        if (sym_k) begin
                            state <= S_SYNC;
                            zcnt  <= CNT_W'(1);
                        end
                    end

                    S_SYNC: begin
                        if (sym_se0 || sym_se1) begin
                            state <= S_IDLE;
                        end else if (!nrzi_bit) begin
                            if (zcnt != CNT_W'(7)) begin
                                zcnt <= zcnt + CNT_W'(1);
                            end
                        end else if (zcnt >= CNT_W'(3)) begin
                            state     <= S_ACTIVE;
                            ones      <= '0;
                            ll_start  <= 1'b1;
                            ll_active <= 1'b1;
                        end else begin
                            state <= S_IDLE;
                        end
                    end

                    S_ACTIVE: begin
                        if (sym_j || sym_k) begin
                            if (ones == CNT_W'(6)) begin
                                if (!nrzi_bit) begin
                                    ones <= '0;
                                end else begin
                                    ll_err <= 1'b1;
                                    state  <= S_ERROR;
                                end
                            end else begin
                                ll_valid <= 1'b1;
                                ll_data  <= nrzi_bit;
                                ones     <= nrzi_bit ? ones + CNT_W'(1) : '0;
                            end
                        end else if (sym_se0) begin
                            state  <= S_EOP;
                            se0cnt <= CNT_W'(1);
                        end else begin
                            ll_err <= 1'b1;
                            state  <= S_ERROR;
                        end
                    end

                    S_EOP: begin
                        if (sym_se0) begin
                            if (se0cnt == CNT_W'(3)) begin
                                ll_err <= 1'b1;
                                state  <= S_ERROR;
                            end else begin
                                se0cnt <= se0cnt + CNT_W'(1);
                            end
                        end else if (sym_j) begin
                            ll_eop <= 1'b1;
                            state  <= S_IDLE;
                        end else begin
                            ll_err <= 1'b1;
                            state  <= S_ERROR;
                        end
                    end

                    S_ERROR: begin
                        if (sym_j) begin
                            if (se0_seen || (jcnt == JCNT_W'(IDLE_BITS - 1))) begin
                                state <= S_IDLE;
                            end else begin
                                jcnt <= jcnt + JCNT_W'(1);
                            end
                        end else if (sym_se0) begin
                            se0_seen <= 1'b1;
                            jcnt     <= '0;
                        end else begin
                            se0_seen <= 1'b0;
                            jcnt     <= '0;
                        end
                    end

                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_usb_rx_ll.sv
// Directed self-checking bench for usb_rx_ll: NRZI/bit-stuffed packets driven at
// 4 clk/bit (and jittered), with event counters checked after each scenario.
module tb_usb_rx_ll;
    localparam logic [1:0] SJ  = 2'b10;
    localparam logic [1:0] SK  = 2'b01;
    localparam logic [1:0] SE0 = 2'b00;
    localparam logic [1:0] SE1 = 2'b11;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic dp    = 1'b1;
    logic dn    = 1'b0;
    logic chg   = 1'b0;
    logic rx_en = 1'b1;
    logic ll_start, ll_valid, ll_data, ll_eop, ll_err, ll_active;

    int checks   = 0;
    int failures = 0;

    logic [1:0] line = SJ;

    int   n_start = 0, n_valid = 0, n_eop = 0, n_err = 0, n_overlap = 0;
    logic bits [0:1023];
    logic act_at_end = 1'b0, act_after_end = 1'b0, end_prev = 1'b0;
    int   b_start, b_valid, b_eop, b_err;

    always #5 clk = ~clk;

    usb_rx_ll dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .phy_rx_dp  (dp),
        .phy_rx_dn  (dn),
        .phy_rx_chg (chg),
        .rx_en      (rx_en),
        .ll_start   (ll_start),
        .ll_valid   (ll_valid),
        .ll_data    (ll_data),
        .ll_eop     (ll_eop),
        .ll_err     (ll_err),
        .ll_active  (ll_active)
    );

    // Event monitor on the falling edge, away from register updates
    always @(negedge clk) begin
        if ($countones({ll_start, ll_valid, ll_eop, ll_err}) > 1) n_overlap++;
        if (end_prev) act_after_end = ll_active;
        if (ll_eop || ll_err) act_at_end = ll_active;
        end_prev = ll_eop || ll_err;
        if (ll_start) n_start++;
        if (ll_eop) n_eop++;
        if (ll_err) n_err++;
        if (ll_valid) begin
            if (n_valid < 1024) bits[n_valid] = ll_data;
            n_valid++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] got_byte(input int base);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = bits[base + i];
        return r;
    endfunction

    task automatic snap();
        b_start = n_start;
        b_valid = n_valid;
        b_eop   = n_eop;
        b_err   = n_err;
    endtask

    task automatic result(input string tag, input int es, input int ev, input int ee, input int er);
        @(posedge clk);
        #1;
        chk({tag, "_start"}, n_start - b_start, es);
        chk({tag, "_valid"}, n_valid - b_valid, ev);
        chk({tag, "_eop"},   n_eop - b_eop,     ee);
        chk({tag, "_err"},   n_err - b_err,     er);
    endtask

    task automatic drive(input logic [1:0] s, input int n);
        @(negedge clk);
        chg = ({dp, dn} != s);
        {dp, dn} = s;
        for (int i = 1; i < n; i++) begin
            @(negedge clk);
            chg = 1'b0;
        end
    endtask

    // NRZI encoder: a 0 toggles the line, a 1 holds it; jit alternates 3/5-cycle bits
    task automatic tx_bits(input logic [63:0] v, input int n, input bit jit);
        for (int i = 0; i < n; i++) begin
            if (!v[i]) line = (line == SJ) ? SK : SJ;
            drive(line, jit ? ((i % 2 == 0) ? 3 : 5) : 4);
        end
    endtask

    task automatic eop(input int nse0);
        drive(SE0, 4 * nse0);
        line = SJ;
        drive(SJ, 32);
    endtask

    task automatic pkt(input logic [7:0] b, input bit jit);
        tx_bits(64'h80, 8, 1'b0);
        tx_bits({56'h0, b}, 8, jit);
        eop(2);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("reset_outputs", {ll_start, ll_valid, ll_data, ll_eop, ll_err, ll_active}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(SJ, 16);

        // Full SYNC + PID 0xA5 + EOP
        snap();
        pkt(8'hA5, 1'b0);
        result("pid", 1, 8, 1, 0);
        chk("pid_byte", got_byte(b_valid), 8'hA5);
        chk("pid_active_at_eop", act_at_end, 1);
        chk("pid_active_after_eop", act_after_end, 0);

        // 0xFF with stuffed 0 after the sixth one
        snap();
        tx_bits(64'h80, 8, 1'b0);
        tx_bits(64'h1BF, 9, 1'b0);
        eop(2);
        result("stuff", 1, 8, 1, 0);
        chk("stuff_byte", got_byte(b_valid), 8'hFF);

        // Seven ones: stuff error, then ERROR holds until 7 consecutive J samples
        snap();
        tx_bits(64'h80, 8, 1'b0);
        tx_bits(64'h7F, 7, 1'b0);
        result("stufferr", 1, 6, 0, 1);
        chk("stufferr_active_after", act_after_end, 0);
        snap();
        line = SJ;
        drive(SJ, 24);
        tx_bits(64'h80, 8, 1'b0);
        tx_bits(64'hA5, 8, 1'b0);
        line = SJ;
        drive(SJ, 28);
        result("inerror", 0, 0, 0, 0);
        snap();
        pkt(8'h3A, 1'b0);
        result("recover", 1, 8, 1, 0);
        chk("recover_byte", got_byte(b_valid), 8'h3A);

        // Truncated SYNC KJKK is accepted
        snap();
        tx_bits(64'h8, 4, 1'b0);
        tx_bits(64'hA5, 8, 1'b0);
        eop(2);
        result("shortsync", 1, 8, 1, 0);
        chk("shortsync_byte", got_byte(b_valid), 8'hA5);

        // SYNC of KK is rejected
        snap();
        tx_bits(64'h2, 2, 1'b0);
        line = SJ;
        drive(SJ, 16);
        result("kk", 0, 0, 0, 0);

        // Jittered 3/5-cycle data bits
        snap();
        pkt(8'h3C, 1'b1);
        result("jitter", 1, 8, 1, 0);
        chk("jitter_byte", got_byte(b_valid), 8'h3C);

        // Three SE0 bit-times still form a valid EOP
        snap();
        tx_bits(64'h80, 8, 1'b0);
        tx_bits(64'h96, 8, 1'b0);
        eop(3);
        result("eop3", 1, 8, 1, 0);

        // Four SE0 bit-times is a framing error; SE0 then J leaves ERROR
        snap();
        tx_bits(64'h80, 8, 1'b0);
        tx_bits(64'h96, 8, 1'b0);
        drive(SE0, 20);
        line = SJ;
        drive(SJ, 8);
        result("eop4", 1, 8, 0, 1);
        snap();
        pkt(8'hC3, 1'b0);
        result("after_se0j", 1, 8, 1, 0);
        chk("after_se0j_byte", got_byte(b_valid), 8'hC3);

        // SE1 inside a packet
        snap();
        tx_bits(64'h80, 8, 1'b0);
        tx_bits(64'h5, 3, 1'b0);
        drive(SE1, 8);
        line = SJ;
        drive(SJ, 32);
        result("se1", 1, 3, 0, 1);

        // Asynchronous reset mid-packet
        tx_bits(64'h80, 8, 1'b0);
        tx_bits(64'h5, 4, 1'b0);
        @(posedge clk);
        #1;
        chk("rst_pre_active", ll_active, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outputs", {ll_start, ll_valid, ll_data, ll_eop, ll_err, ll_active}, 0);
        line = SJ;
        drive(SJ, 8);
        @(negedge clk);
        rst_n = 1'b1;
        drive(SJ, 16);

        // rx_en dropped mid-packet: one abort pulse
        snap();
        tx_bits(64'h80, 8, 1'b0);
        tx_bits(64'h5, 4, 1'b0);
        @(negedge clk);
        rx_en = 1'b0;
        line = SJ;
        drive(SJ, 12);
        @(negedge clk);
        rx_en = 1'b1;
        drive(SJ, 8);
        result("rxen", 1, 4, 0, 1);
        chk("rxen_active_at_err", act_at_end, 1);
        chk("rxen_active_after", act_after_end, 0);
        snap();
        pkt(8'h5A, 1'b0);
        result("after_rxen", 1, 8, 1, 0);
        chk("after_rxen_byte", got_byte(b_valid), 8'h5A);

        chk("pulse_overlap", n_overlap, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
